// File: rtl/spi_slave_rx_tx_if.sv
// Bus bundle for the SPI responder: the SPI pins plus the local-side
// TX load and RX/status interface.
//   slave  modport : used by spi_slave_rx_tx (SPI pins and tx_* in, miso/status out)
//   master modport : used by whatever drives the link and consumes rx_data
// Signals: sclk, ss (active-low), mosi, miso, miso_oe, tx_data, tx_load,
//          rx_data, rx_valid, busy, tx_underrun, frame_err.
interface spi_slave_rx_tx_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              ss;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              tx_underrun;
  logic              frame_err;

  modport slave (
    input  sclk, ss, mosi, tx_data, tx_load,
    output miso, miso_oe, rx_data, rx_valid, busy, tx_underrun, frame_err
  );

  modport master (
    output sclk, ss, mosi, tx_data, tx_load,
    input  miso, miso_oe, rx_data, rx_valid, busy, tx_underrun, frame_err
  );
endinterface

// File: rtl/spi_slave_rx_tx.sv
// SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first. sclk/ss/mosi are
// oversampled on global_clk through 2-flop synchronisers; edges are taken
// from the 2nd flop against a 3rd history flop.
// Ports:
//   global_clk : system clock, all logic on posedge
//   reset      : asynchronous, active-high
//   bus        : spi_slave_rx_tx_if.slave
//                sclk/ss/mosi in, miso/miso_oe out,
//                tx_data/tx_load in (TX holding register load),
//                rx_data/rx_valid out (last received word, 1-cycle strobe),
//                busy, tx_underrun, frame_err status out.
module spi_slave_rx_tx #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] DEFAULT_TX = {DATA_W{1'b1}}
) (
  input  logic                   global_clk,
  input  logic                   reset,
  spi_slave_rx_tx_if.slave       bus
);
  localparam int                CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic ss_p0, ss_p1, ss_p2;
  logic mosi_p0, mosi_p1;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic start_idle, start_b2b;

  logic [DATA_W-1:0] shift_tx, shift_rx, tx_hold, rx_data_r;
  logic [CNT_W-1:0]  bit_cnt;
  logic              tx_pending, und_arm;
  logic              rx_valid_r, tx_underrun_r, frame_err_r;

  // Stage p0/p1: two-flop synchronisers; p2: edge history
  always_ff @(posedge global_clk or posedge reset) begin
    if (reset) begin
      sclk_p0 <= 1'b0; sclk_p1 <= 1'b0; sclk_p2 <= 1'b0;
      ss_p0   <= 1'b1; ss_p1   <= 1'b1; ss_p2   <= 1'b1;
      mosi_p0 <= 1'b0; mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= bus.sclk; sclk_p1 <= sclk_p0; sclk_p2 <= sclk_p1;
      ss_p0   <= bus.ss;   ss_p1   <= ss_p0;   ss_p2   <= ss_p1;
      mosi_p0 <= bus.mosi; mosi_p1 <= mosi_p0;
    end
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign ss_fall   = ~ss_p1 & ss_p2;
  assign ss_rise   = ss_p1 & ~ss_p2;

  always_ff @(posedge global_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_idle = 1'b0;
    start_b2b  = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt  = SHIFT;
          start_idle = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) state_nxt = IDLE;
        else start_b2b = ~ss_p1 & sclk_fall & (bit_cnt == FULL);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p3: shift, word framing and status pulses
  always_ff @(posedge global_clk or posedge reset) begin
    if (reset) begin
      shift_tx      <= '0;
      shift_rx      <= '0;
      tx_hold       <= '0;
      rx_data_r     <= '0;
      bit_cnt       <= '0;
      tx_pending    <= 1'b0;
      und_arm       <= 1'b0;
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      frame_err_r   <= 1'b0;
      if (bus.tx_load) begin
        tx_hold    <= bus.tx_data;
        tx_pending <= 1'b1;
      end
      if (start_idle || start_b2b) begin
        // A same-cycle tx_load bypasses the holding register.
        shift_tx   <= bus.tx_load ? bus.tx_data : (tx_pending ? tx_hold : DEFAULT_TX);
        tx_pending <= 1'b0;
        bit_cnt    <= '0;
        // The trailing sclk fall of every word starts a new one; its
        // underrun is only reported once that word really clocks a bit,
        // so a frame ending cleanly after its last word stays silent.
        if (start_idle) tx_underrun_r <= ~tx_pending & ~bus.tx_load;
        else            und_arm       <= ~tx_pending & ~bus.tx_load;
      end else if (state == SHIFT) begin
        if (ss_rise) begin
          frame_err_r <= (bit_cnt != '0) && (bit_cnt != FULL);
          und_arm     <= 1'b0;
        end else if (sclk_rise && bit_cnt != FULL) begin
          shift_rx <= {shift_rx[DATA_W-2:0], mosi_p1};
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            rx_data_r  <= {shift_rx[DATA_W-2:0], mosi_p1};
            rx_valid_r <= 1'b1;
          end
          if (und_arm) begin
            tx_underrun_r <= 1'b1;
            und_arm       <= 1'b0;
          end
        end else if (sclk_fall && bit_cnt != FULL) begin
          shift_tx <= shift_tx << 1;
        end
      end
    end
  end

  assign bus.busy        = (state == SHIFT);
  assign bus.miso_oe     = (state == SHIFT) & ~ss_p1;
  assign bus.miso        = bus.miso_oe & shift_tx[DATA_W-1];
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.tx_underrun = tx_underrun_r;
  assign bus.frame_err   = frame_err_r;
endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx: an SPI master model drives frames,
// collects miso bits at each sclk rise and queues every completed mosi word;
// a negedge monitor checks rx_data against that queue every cycle and
// counts the status pulses.
module tb_spi_slave_rx_tx;
  localparam int DATA_W = 8;
  localparam int HALF   = 6;

  logic global_clk = 1'b0;
  logic reset      = 1'b1;
  always #5 global_clk = ~global_clk;

  spi_slave_rx_tx_if #(.DATA_W(DATA_W)) bus();

  spi_slave_rx_tx #(.DATA_W(DATA_W), .DEFAULT_TX(8'hFF)) dut (
    .global_clk(global_clk),
    .reset     (reset),
    .bus       (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rxv_cnt = 0, und_cnt = 0, ferr_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] model_last = 8'h00;
  logic [7:0] got, got1, got2;
  int u0, r0, f0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge global_clk) begin
    if (!reset) begin
      if (bus.rx_valid) begin
        rxv_cnt++;
        if (exp_rx.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_valid_unexpected: got rx_data %0h with no word sent", bus.rx_data);
        end else begin
          model_last = exp_rx.pop_front();
        end
      end
      chk("rx_data_track", 32'(bus.rx_data), 32'(model_last));
      if (bus.tx_underrun) und_cnt++;
      if (bus.frame_err)   ferr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge global_clk);
    #2;
  endtask

  task automatic load(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    tick(1);
    bus.tx_load = 1'b0;
  endtask

  task automatic frame_begin();
    bus.ss = 1'b0;
    tick(8);
  endtask

  task automatic frame_end();
    tick(4);
    bus.ss = 1'b1;
    tick(10);
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits, output logic [7:0] g);
    g = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = w[7-i];
      tick(HALF);
      bus.sclk = 1'b1;
      g = {g[6:0], bus.miso};
      if (i == 7) exp_rx.push_back(w);
      tick(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"},        32'(bus.miso),        32'd0);
    chk({tag, "_miso_oe"},     32'(bus.miso_oe),     32'd0);
    chk({tag, "_rx_data"},     32'(bus.rx_data),     32'd0);
    chk({tag, "_rx_valid"},    32'(bus.rx_valid),    32'd0);
    chk({tag, "_busy"},        32'(bus.busy),        32'd0);
    chk({tag, "_tx_underrun"}, 32'(bus.tx_underrun), 32'd0);
    chk({tag, "_frame_err"},   32'(bus.frame_err),   32'd0);
  endtask

  initial begin
    bus.sclk = 1'b0; bus.ss = 1'b1; bus.mosi = 1'b0;
    bus.tx_load = 1'b0; bus.tx_data = 8'h00;
    tick(3);
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick(2);

    // 1: loaded word A5, master sends 3C
    load(8'hA5);
    u0 = und_cnt; r0 = rxv_cnt;
    frame_begin();
    chk("t1_busy_in_frame", 32'(bus.busy), 32'd1);
    chk("t1_oe_in_frame", 32'(bus.miso_oe), 32'd1);
    send_word(8'h3C, 8, got);
    chk("t1_miso_word", 32'(got), 32'h A5);
    frame_end();
    chk("t1_rx_data", 32'(bus.rx_data), 32'h3C);
    chk("t1_rx_valid_count", 32'(rxv_cnt - r0), 32'd1);
    chk("t1_underrun_count", 32'(und_cnt - u0), 32'd0);
    chk("t1_busy_after", 32'(bus.busy), 32'd0);
    chk("t1_oe_after", 32'(bus.miso_oe), 32'd0);

    // 2: no load -> default word, one underrun
    u0 = und_cnt; r0 = rxv_cnt;
    frame_begin();
    send_word(8'h81, 8, got);
    frame_end();
    chk("t2_miso_word", 32'(got), 32'hFF);
    chk("t2_underrun_count", 32'(und_cnt - u0), 32'd1);
    chk("t2_rx_data", 32'(bus.rx_data), 32'h81);
    chk("t2_rx_valid_count", 32'(rxv_cnt - r0), 32'd1);

    // 3: two back-to-back words, second load during word 1
    u0 = und_cnt; r0 = rxv_cnt;
    load(8'h12);
    frame_begin();
    fork
      send_word(8'hC3, 8, got1);
      begin
        tick(20);
        load(8'h34);
      end
    join
    send_word(8'h7E, 8, got2);
    frame_end();
    chk("t3_miso_word1", 32'(got1), 32'h12);
    chk("t3_miso_word2", 32'(got2), 32'h34);
    chk("t3_rx_valid_count", 32'(rxv_cnt - r0), 32'd2);
    chk("t3_underrun_count", 32'(und_cnt - u0), 32'd0);
    chk("t3_rx_data", 32'(bus.rx_data), 32'h7E);

    // 4: ss rises after 3 bits
    f0 = ferr_cnt; r0 = rxv_cnt;
    frame_begin();
    send_word(8'hE0, 3, got);
    frame_end();
    chk("t4_frame_err_count", 32'(ferr_cnt - f0), 32'd1);
    chk("t4_rx_valid_count", 32'(rxv_cnt - r0), 32'd0);
    chk("t4_rx_data_held", 32'(bus.rx_data), 32'h7E);
    chk("t4_busy_after", 32'(bus.busy), 32'd0);

    // 5: reset at bit 5, then a fresh frame
    frame_begin();
    send_word(8'hAA, 5, got);
    tick(2);
    reset = 1'b1;
    model_last = 8'h00;
    #1;
    chk_reset_outputs("t5_async");
    bus.ss = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3);
    u0 = und_cnt; r0 = rxv_cnt; f0 = ferr_cnt;
    load(8'hA5);
    frame_begin();
    send_word(8'h3C, 8, got);
    frame_end();
    chk("t5_miso_word", 32'(got), 32'hA5);
    chk("t5_rx_data", 32'(bus.rx_data), 32'h3C);
    chk("t5_rx_valid_count", 32'(rxv_cnt - r0), 32'd1);
    chk("t5_underrun_count", 32'(und_cnt - u0), 32'd0);
    chk("t5_frame_err_count", 32'(ferr_cnt - f0), 32'd0);

    // 6: tx_load in the very cycle of the word-start load
    u0 = und_cnt; r0 = rxv_cnt;
    bus.ss = 1'b0;
    tick(2);
    bus.tx_data = 8'h5A;
    bus.tx_load = 1'b1;
    tick(1);
    bus.tx_load = 1'b0;
    tick(5);
    send_word(8'h66, 8, got);
    frame_end();
    chk("t6_miso_word", 32'(got), 32'h5A);
    chk("t6_underrun_count", 32'(und_cnt - u0), 32'd0);
    chk("t6_rx_valid_count", 32'(rxv_cnt - r0), 32'd1);
    chk("t6_rx_data", 32'(bus.rx_data), 32'h66);

    chk("exp_rx_drained", 32'(exp_rx.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
